// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the two-port memory arbiter
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

    localparam int NPORTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/arb_rr2.sv
// ----------------------------------------------------------------------------
// arb_rr2 : two-requester winner select, round-robin or port-0 fixed priority
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic              last,
    input  logic              rr,
    output logic              winner
);

    always_comb begin
        winner = 1'b0;
        if (&req) begin
            winner = rr ? ~last : 1'b0;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter : shares one single-cycle memory between two requesters
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RR = 1,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wmask,
    output logic          m0_gnt,
    output logic [31:0]   m0_rdata,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wmask,
    output logic          m1_gnt,
    output logic [31:0]   m1_rdata,
    output logic          m1_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rstrb,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic [31:0]   mem_rdata
);

    state_t                  state_q, state_d;
    logic                    win_q, we_q, last_q;
    logic [AW-1:0]           addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wmask_q;
    logic [NPORTS-1:0][31:0] rdata_q;
    logic [NPORTS-1:0]       rvalid_q;

    logic [NPORTS-1:0]       w_req;
    logic                    w_winner;
    logic                    w_accept;

    assign w_req    = {m1_req, m0_req};
    assign w_accept = (state_q == IDLE) && (|w_req);

    arb_rr2 u_arb (
        .req    (w_req),
        .last   (last_q),
        .rr     (RR != 0),
        .winner (w_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|w_req) state_d = ACCESS;
            ACCESS:  state_d = we_q ? IDLE : RDATA;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The winner's command is captured at acceptance so requesters may drop
    // or change their inputs as soon as they see the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= '0;
            if (w_accept) begin
                win_q   <= w_winner;
                last_q  <= w_winner;
                we_q    <= w_winner ? m1_we    : m0_we;
                addr_q  <= w_winner ? m1_addr  : m0_addr;
                wdata_q <= w_winner ? m1_wdata : m0_wdata;
                wmask_q <= w_winner ? m1_wmask : m0_wmask;
            end
            if (state_q == RDATA) begin
                rdata_q[win_q]  <= mem_rdata;
                rvalid_q[win_q] <= 1'b1;
            end
        end
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_rstrb = 1'b0;
        mem_wmask = 4'b0;
        if (state_q == ACCESS) begin
            m0_gnt    = ~win_q;
            m1_gnt    = win_q;
            mem_rstrb = ~we_q;
            mem_wmask = we_q ? wmask_q : 4'b0;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter : scoreboard bench for mem_arbiter (round-robin and fixed)
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          cyc;
    } gnt_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rv_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wmask [2];
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [31:0] mem [256];

    logic [1:0]  fp_req = 2'b00;
    logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid, fp_rstrb;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_addr, fp_wdata;
    logic [3:0]  fp_wmask;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          fp_seen = 0;
    gnt_t        exp_gnt [$];
    rv_t         exp_rv0 [$];
    rv_t         exp_rv1 [$];
    int          fp_exp [$];
    logic [31:0] model_rd [2];
    gnt_t        mon_e;
    rv_t         mon_r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.RR(1), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_wmask(wmask[0]),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_wmask(wmask[1]),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.RR(0), .AW(32)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(fp_req[0]), .m0_we(1'b1), .m0_addr(32'h0), .m0_wdata(32'h0), .m0_wmask(4'hF),
        .m0_gnt(fp_m0_gnt), .m0_rdata(fp_m0_rdata), .m0_rvalid(fp_m0_rvalid),
        .m1_req(fp_req[1]), .m1_we(1'b1), .m1_addr(32'h4), .m1_wdata(32'h0), .m1_wmask(4'hF),
        .m1_gnt(fp_m1_gnt), .m1_rdata(fp_m1_rdata), .m1_rvalid(fp_m1_rvalid),
        .mem_addr(fp_addr), .mem_rstrb(fp_rstrb), .mem_wdata(fp_wdata),
        .mem_wmask(fp_wmask), .mem_rdata(32'h0)
    );

    // Memory model: read data one cycle after the strobe, byte-masked writes.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'h12345678;
        mem[5] = 32'hCAFEF00D;
    end

    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            model_rd[0] = 32'h0;
            model_rd[1] = 32'h0;
        end else begin
            if (m0_gnt || m1_gnt) check("gnt_onehot", {63'b0, m0_gnt & m1_gnt}, 64'd0);
            if (mem_rstrb || (mem_wmask != 4'h0)) check("strobe_in_access", {63'b0, m0_gnt | m1_gnt}, 64'd1);
            for (int p = 0; p < 2; p++) begin
                if (p == 0 ? m0_gnt : m1_gnt) begin
                    if (exp_gnt.size() == 0) begin
                        check("unexpected_gnt", p, 99);
                    end else begin
                        mon_e = exp_gnt.pop_front();
                        check("gnt_port", p, mon_e.port);
                        if (mon_e.cyc >= 0) check("gnt_cycle", cyc, mon_e.cyc);
                        check("mem_rstrb", {63'b0, mem_rstrb}, {63'b0, ~mon_e.we});
                        check("mem_addr", mem_addr, mon_e.addr);
                        check("mem_wmask", mem_wmask, mon_e.we ? mon_e.wmask : 4'h0);
                        if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.wdata);
                    end
                end
                if (p == 0 ? m0_rvalid : m1_rvalid) begin
                    if ((p == 0 ? exp_rv0.size() : exp_rv1.size()) == 0) begin
                        check("unexpected_rvalid", p, 99);
                    end else begin
                        mon_r = (p == 0) ? exp_rv0.pop_front() : exp_rv1.pop_front();
                        check("rvalid_cycle", cyc, mon_r.cyc);
                        check("rdata", p == 0 ? m0_rdata : m1_rdata, mon_r.data);
                        check("other_rdata_hold", p == 0 ? m1_rdata : m0_rdata, model_rd[1-p]);
                        model_rd[p] = mon_r.data;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (p == 0 ? fp_m0_gnt : fp_m1_gnt) begin
                    fp_seen++;
                    if (fp_exp.size() == 0) check("fp_unexpected_gnt", p, 99);
                    else check("fp_gnt_port", p, fp_exp.pop_front());
                end
            end
        end
    end

    task automatic wait_gnt(int p);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (p == 0 ? m0_gnt : m1_gnt) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout: port %0d got no grant, expected one within 40 cycles", p);
        end
    endtask

    task automatic push_gnt(int p, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] m, int c);
        gnt_t e;
        e.port = p; e.we = w; e.addr = a; e.wdata = d; e.wmask = m; e.cyc = c;
        exp_gnt.push_back(e);
    endtask

    task automatic push_rv(int p, logic [31:0] d, int c);
        rv_t r;
        r.data = d; r.cyc = c;
        if (p == 0) exp_rv0.push_back(r);
        else exp_rv1.push_back(r);
    endtask

    // Called on a falling edge; returns on the falling edge where the next
    // request from this port can be accepted on the following rising edge.
    task automatic xfer(int p, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                        logic [31:0] exp_rd, bit push);
        if (push) begin
            push_gnt(p, w, a, d, m, cyc + 1);
            if (!w) push_rv(p, exp_rd, cyc + 3);
        end
        we[p] = w; addr[p] = a; wdata[p] = d; wmask[p] = m;
        req[p] = 1'b1;
        wait_gnt(p);
        req[p] = 1'b0;
        repeat (w ? 1 : 2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_gnt"}, {62'b0, m1_gnt, m0_gnt}, 64'd0);
        check({tag, "_rvalid"}, {62'b0, m1_rvalid, m0_rvalid}, 64'd0);
        check({tag, "_rstrb_wmask"}, {59'b0, mem_rstrb, mem_wmask}, 64'd0);
        check({tag, "_addr_wdata"}, {mem_addr, mem_wdata}, 64'd0);
        check({tag, "_rdata"}, {m1_rdata, m0_rdata}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            addr[i] = 32'h0; wdata[i] = 32'h0; wmask[i] = 4'h0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h12345678, 1'b1);
        xfer(1, 1'b1, 32'h20, 32'hDEADBEEF, 4'b0011, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0000BEEF, 1'b1);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h12345678, 1'b1);

        // Continuous contention with round-robin: grants alternate 0,1,0,1.
        push_gnt(0, 1'b1, 32'h40, 32'hA0A0A0A0, 4'hF, -1);
        push_gnt(1, 1'b1, 32'h44, 32'hB1B1B1B1, 4'hF, -1);
        push_gnt(0, 1'b1, 32'h40, 32'hA0A0A0A0, 4'hF, -1);
        push_gnt(1, 1'b1, 32'h44, 32'hB1B1B1B1, 4'hF, -1);
        fork
            repeat (2) xfer(0, 1'b1, 32'h40, 32'hA0A0A0A0, 4'hF, 32'h0, 1'b0);
            repeat (2) xfer(1, 1'b1, 32'h44, 32'hB1B1B1B1, 4'hF, 32'h0, 1'b0);
        join
        repeat (2) @(negedge clk);

        // Back-to-back writes: one grant every two cycles.
        xfer(0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'b0001, 32'h0, 1'b1);
        xfer(0, 1'b1, 32'h34, 32'hA5A5A5A5, 4'b0010, 32'h0, 1'b1);
        xfer(0, 1'b1, 32'h38, 32'hA5A5A5A5, 4'b0100, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h34, 32'h0, 4'h0, 32'h0000A500, 1'b1);

        // Port 1 arrives while port 0's read is in ACCESS; it waits out RDATA.
        push_gnt(0, 1'b0, 32'h10, 32'h0, 4'h0, cyc + 1);
        push_rv(0, 32'h12345678, cyc + 3);
        we[0] = 1'b0; addr[0] = 32'h10; req[0] = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        push_gnt(1, 1'b1, 32'h24, 32'h11223344, 4'hF, cyc + 3);
        we[1] = 1'b1; addr[1] = 32'h24; wdata[1] = 32'h11223344; wmask[1] = 4'hF; req[1] = 1'b1;
        wait_gnt(1);
        req[1] = 1'b0;
        @(negedge clk);
        xfer(0, 1'b0, 32'h24, 32'h0, 4'h0, 32'h11223344, 1'b1);

        // Fixed priority: port 0 wins every contention.
        repeat (4) fp_exp.push_back(0);
        fp_req = 2'b11;
        for (int k = 0; k < 40 && fp_seen < 4; k++) @(negedge clk);
        fp_req = 2'b00;
        check("fp_grant_count", fp_seen, 4);
        repeat (3) @(negedge clk);

        // Reset while the read is in RDATA: outputs clear at once, no rvalid.
        push_gnt(0, 1'b0, 32'h14, 32'h0, 4'h0, cyc + 1);
        we[0] = 1'b0; addr[0] = 32'h14; req[0] = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1);

        repeat (6) @(negedge clk);
        check("gnt_queue_left", exp_gnt.size(), 0);
        check("rv0_queue_left", exp_rv0.size(), 0);
        check("rv1_queue_left", exp_rv1.size(), 0);
        check("fp_queue_left", fp_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
